// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU opcodes, register $0.
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Register $0 is hardwired to zero and is never a forwarding source.
  localparam logic [RW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB, which beats the
// registered value. Writes to $0 are never forwarded.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] reg_addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic [DW-1:0] fwd_data
);

  logic exm_hit;
  logic mwb_hit;

  // Priority select of the freshest producer for this operand.
  always_comb begin
    exm_hit  = exm_reg_write && (exm_rd != RW'(REG_ZERO)) && (exm_rd == reg_addr);
    mwb_hit  = mwb_reg_write && (mwb_rd != RW'(REG_ZERO)) && (mwb_rd == reg_addr);
    fwd_data = reg_data;
    if (exm_hit) begin
      fwd_data = exm_result;
    end else if (mwb_hit) begin
      fwd_data = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded operands and
// control, forwards from EX/MEM and MEM/WB, and inserts a bubble on a
// load-use hazard, a flush, or an empty decode slot.
//
// Flow control: there is no ready input. stall is the backpressure to
// PC/IF-ID: while stall=1 the decode stage must hold its instruction
// unchanged, and this stage loads a bubble instead of capturing it. The
// decode instruction is accepted on any rising edge where id_valid=1,
// stall=0 and flush=0.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src_imm,
  input  logic [4:0]    id_shamt,
  input  logic [2:0]    id_alu_ctrl,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] opA,
  output logic [DW-1:0] opB,
  output logic [4:0]    shamt,
  output logic [2:0]    alu_control_signal,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [DW-1:0] store_data
);

  logic          valid_q,       valid_d;
  logic [RW-1:0] rs_q,          rs_d;
  logic [RW-1:0] rt_q,          rt_d;
  logic [DW-1:0] rs_data_q,     rs_data_d;
  logic [DW-1:0] rt_data_q,     rt_data_d;
  logic [DW-1:0] imm_q,         imm_d;
  logic          alu_src_imm_q, alu_src_imm_d;
  logic [4:0]    shamt_q,       shamt_d;
  logic [2:0]    alu_ctrl_q,    alu_ctrl_d;
  logic [RW-1:0] rd_q,          rd_d;
  logic          reg_write_q,   reg_write_d;
  logic          mem_read_q,    mem_read_d;
  logic          mem_write_q,   mem_write_d;

  logic          hazard;
  logic          load_bubble;
  logic          wb_rs_hit;
  logic          wb_rt_hit;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Load-use detection against the load currently in EX.
  always_comb begin
    hazard = valid_q && mem_read_q && (rd_q != RW'(REG_ZERO)) && id_valid &&
             ((id_rs == rd_q) || (id_uses_rt && (id_rt == rd_q)));
    stall       = hazard && !flush;
    load_bubble = flush || hazard || !id_valid;
  end

  // Next-state: bubble or capture, with WB bypass of the regfile read data
  // (the regfile write in WB lands too late for this cycle's read).
  always_comb begin
    wb_rs_hit = mwb_reg_write && (mwb_rd != RW'(REG_ZERO)) && (mwb_rd == id_rs);
    wb_rt_hit = mwb_reg_write && (mwb_rd != RW'(REG_ZERO)) && (mwb_rd == id_rt);

    valid_d       = 1'b0;
    rs_d          = '0;
    rt_d          = '0;
    rs_data_d     = '0;
    rt_data_d     = '0;
    imm_d         = '0;
    alu_src_imm_d = 1'b0;
    shamt_d       = '0;
    alu_ctrl_d    = ALU_ADD;
    rd_d          = '0;
    reg_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;

    if (!load_bubble) begin
      valid_d       = 1'b1;
      rs_d          = id_rs;
      rt_d          = id_rt;
      rs_data_d     = wb_rs_hit ? mwb_result : id_rs_data;
      rt_data_d     = wb_rt_hit ? mwb_result : id_rt_data;
      imm_d         = id_imm;
      alu_src_imm_d = id_alu_src_imm;
      shamt_d       = id_shamt;
      alu_ctrl_d    = id_alu_ctrl;
      rd_d          = id_rd;
      reg_write_d   = id_reg_write;
      mem_read_d    = id_mem_read;
      mem_write_d   = id_mem_write;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      alu_src_imm_q <= 1'b0;
      shamt_q       <= '0;
      alu_ctrl_q    <= ALU_ADD;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      alu_src_imm_q <= alu_src_imm_d;
      shamt_q       <= shamt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .reg_addr      (rs_q),
    .reg_data      (rs_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .reg_addr      (rt_q),
    .reg_data      (rt_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rt)
  );

  // ALU-facing outputs; control is gated by valid so bubbles are inert.
  always_comb begin
    ex_valid           = valid_q;
    opA                = fwd_rs;
    opB                = alu_src_imm_q ? imm_q : fwd_rt;
    store_data         = fwd_rt;
    shamt              = shamt_q;
    alu_control_signal = alu_ctrl_q;
    ex_rd              = rd_q;
    ex_reg_write       = reg_write_q && valid_q;
    ex_mem_read        = mem_read_q && valid_q;
    ex_mem_write       = mem_write_q && valid_q;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority,
// load-use stall, flush, immediate/shift operands, opcode passthrough.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_uses_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_alu_src_imm;
  logic [4:0]    id_shamt;
  logic [2:0]    id_alu_ctrl;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          flush;
  logic          exm_reg_write;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_result;
  logic          mwb_reg_write;
  logic [RW-1:0] mwb_rd;
  logic [DW-1:0] mwb_result;
  logic          stall;
  logic          ex_valid;
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  logic [4:0]    shamt;
  logic [2:0]    alu_control_signal;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [DW-1:0] store_data;

  int n_checks;
  int n_pass;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_valid           (id_valid),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_uses_rt         (id_uses_rt),
    .id_rs_data         (id_rs_data),
    .id_rt_data         (id_rt_data),
    .id_imm             (id_imm),
    .id_alu_src_imm     (id_alu_src_imm),
    .id_shamt           (id_shamt),
    .id_alu_ctrl        (id_alu_ctrl),
    .id_rd              (id_rd),
    .id_reg_write       (id_reg_write),
    .id_mem_read        (id_mem_read),
    .id_mem_write       (id_mem_write),
    .flush              (flush),
    .exm_reg_write      (exm_reg_write),
    .exm_rd             (exm_rd),
    .exm_result         (exm_result),
    .mwb_reg_write      (mwb_reg_write),
    .mwb_rd             (mwb_rd),
    .mwb_result         (mwb_result),
    .stall              (stall),
    .ex_valid           (ex_valid),
    .opA                (opA),
    .opB                (opB),
    .shamt              (shamt),
    .alu_control_signal (alu_control_signal),
    .ex_rd              (ex_rd),
    .ex_reg_write       (ex_reg_write),
    .ex_mem_read        (ex_mem_read),
    .ex_mem_write       (ex_mem_write),
    .store_data         (store_data)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid       = 1'b0;
    id_rs          = '0;
    id_rt          = '0;
    id_uses_rt     = 1'b0;
    id_rs_data     = '0;
    id_rt_data     = '0;
    id_imm         = '0;
    id_alu_src_imm = 1'b0;
    id_shamt       = '0;
    id_alu_ctrl    = 3'b000;
    id_rd          = '0;
    id_reg_write   = 1'b0;
    id_mem_read    = 1'b0;
    id_mem_write   = 1'b0;
    flush          = 1'b0;
    exm_reg_write  = 1'b0;
    exm_rd         = '0;
    exm_result     = '0;
    mwb_reg_write  = 1'b0;
    mwb_rd         = '0;
    mwb_result     = '0;
  endtask

  // Drive a decoded instruction onto the id_* inputs.
  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic alu_src_imm, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [2:0] ctrl, input logic [4:0] rd,
                          input logic reg_write, input logic mem_read, input logic mem_write);
    id_valid       = 1'b1;
    id_rs          = rs;
    id_rt          = rt;
    id_uses_rt     = uses_rt;
    id_rs_data     = rs_data;
    id_rt_data     = rt_data;
    id_alu_src_imm = alu_src_imm;
    id_imm         = imm;
    id_shamt       = sh;
    id_alu_ctrl    = ctrl;
    id_rd          = rd;
    id_reg_write   = reg_write;
    id_mem_read    = mem_read;
    id_mem_write   = mem_write;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    rst_n = 1'b0;
    #3;

    // Reset state, no clock edge yet
    check("rst_opA", opA, 32'h0);
    check("rst_opB", opB, 32'h0);
    check("rst_store", store_data, 32'h0);
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_alu", 32'(alu_control_signal), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // EX/MEM forwarding: sub $4 = $3 - $5, $3 produced by the add now in EX/MEM
    drive_id(5'd3, 5'd5, 1'b1, 32'h1234, 32'h5, 1'b0, 32'h0, 5'd0, 3'b001, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'h10;
    #1;
    check("exm_opA", opA, 32'h10);
    check("exm_opB", opB, 32'h5);
    check("exm_alu", 32'(alu_control_signal), 32'h1);
    check("exm_ex_valid", 32'(ex_valid), 32'h1);
    check("exm_ex_rd", 32'(ex_rd), 32'h4);
    check("exm_ex_reg_write", 32'(ex_reg_write), 32'h1);

    // Double hazard on $7
    drive_id(5'd7, 5'd7, 1'b1, 32'h11, 32'h22, 1'b0, 32'h0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b0, 1'b0);
    exm_reg_write = 1'b0;
    tick();
    idle_inputs();
    exm_reg_write = 1'b1; exm_rd = 5'd7; exm_result = 32'hAAAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd7; mwb_result = 32'hBBBB;
    #1;
    check("dbl_opA", opA, 32'hAAAA);
    check("dbl_store", store_data, 32'hAAAA);
    exm_reg_write = 1'b0;
    #1;
    check("mwb_only_opA", opA, 32'hBBBB);
    exm_reg_write = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
    #1;
    check("zero_opA", opA, 32'h11);
    check("zero_opB", opB, 32'h22);

    // Load-use: lw $8 then add $9 = $8 + $2
    idle_inputs();
    drive_id(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 1'b1, 32'h4, 5'd0, 3'b000, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(5'd8, 5'd2, 1'b1, 32'hDEAD, 32'h3, 1'b0, 32'h0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_ex_mem_read", 32'(ex_mem_read), 32'h1);
    check("lu_stall", 32'(stall), 32'h1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'h0);
    check("lu_bubble_rw", 32'(ex_reg_write), 32'h0);
    check("lu_stall_drop", 32'(stall), 32'h0);
    mwb_reg_write = 1'b1; mwb_rd = 5'd8; mwb_result = 32'h77;
    tick();
    check("lu_add_valid", 32'(ex_valid), 32'h1);
    check("lu_add_opA", opA, 32'h77);
    check("lu_add_opB", opB, 32'h3);
    mwb_reg_write = 1'b0;
    #1;
    check("lu_captured_bypass", opA, 32'h77);

    // Flush overrides hazard; rt hazard only when the rt read is used
    idle_inputs();
    drive_id(5'd1, 5'd8, 1'b0, 32'h100, 32'h0, 1'b1, 32'h4, 5'd0, 3'b000, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(5'd1, 5'd8, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    check("rt_unused_stall", 32'(stall), 32'h0);
    id_uses_rt = 1'b1;
    #1;
    check("rt_used_stall", 32'(stall), 32'h1);
    id_rs = 5'd8; id_uses_rt = 1'b0; flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'h0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'h0);
    check("flush_mem_read", 32'(ex_mem_read), 32'h0);
    check("flush_reg_write", 32'(ex_reg_write), 32'h0);

    // Immediate operand with rt forwarded to store_data
    idle_inputs();
    drive_id(5'd2, 5'd6, 1'b0, 32'h5, 32'h1, 1'b1, 32'hFFFF_FFFC, 5'd0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    exm_reg_write = 1'b1; exm_rd = 5'd6; exm_result = 32'h99;
    #1;
    check("imm_opA", opA, 32'h5);
    check("imm_opB", opB, 32'hFFFF_FFFC);
    check("imm_store", store_data, 32'h99);
    check("imm_mem_write", 32'(ex_mem_write), 32'h1);

    // Shift: sll with shamt 4
    drive_id(5'd0, 5'd3, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0, 5'd4, 3'b010, 5'd10, 1'b1, 1'b0, 1'b0);
    exm_reg_write = 1'b0;
    tick();
    check("sll_shamt", 32'(shamt), 32'h4);
    check("sll_alu", 32'(alu_control_signal), 32'h2);
    check("sll_opB", opB, 32'h1);

    // Undefined opcode passes through
    drive_id(5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b111, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    check("alu_passthru", 32'(alu_control_signal), 32'h7);

    // Empty decode slot loads a bubble with ADD
    idle_inputs();
    tick();
    check("idle_valid", 32'(ex_valid), 32'h0);
    check("idle_alu", 32'(alu_control_signal), 32'h0);

    // Asynchronous reset mid-stream drops in-flight load and stall
    drive_id(5'd1, 5'd8, 1'b0, 32'h123, 32'h0, 1'b1, 32'h4, 5'd0, 3'b000, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    id_rs = 5'd8; id_mem_read = 1'b0; id_rd = 5'd9;
    #1;
    check("mid_pre_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_valid", 32'(ex_valid), 32'h0);
    check("mid_rst_opA", opA, 32'h0);
    check("mid_rst_opB", opB, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands and control, then drives the ALU inputs opA, opB, shamt and alu_control_signal.
- Resolves data hazards two ways: EX/MEM and MEM/WB forwarding, and load-use stall generation with bubble insertion.
- Also outputs forwarded rt as store data for the MEM stage.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs  in  RW  source register A address
- id_rt  in  RW  source register B address
- id_uses_rt  in  1  instruction reads rt
- id_rs_data  in  DW  regfile read data for rs
- id_rt_data  in  DW  regfile read data for rt
- id_imm  in  DW  sign-extended immediate
- id_alu_src_imm  in  1  opB selects immediate instead of rt
- id_shamt  in  5  shift amount
- id_alu_ctrl  in  3  ALU operation code
- id_rd  in  RW  destination register
- id_reg_write  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- id_mem_write  in  1  instruction is a store
- flush  in  1  branch/jump taken; kill the decode instruction
- exm_reg_write  in  1  EX/MEM stage writes a register
- exm_rd  in  RW  EX/MEM destination
- exm_result  in  DW  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB stage writes a register
- mwb_rd  in  RW  MEM/WB destination
- mwb_result  in  DW  MEM/WB writeback value
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- opA  out  DW  ALU operand A
- opB  out  DW  ALU operand B
- shamt  out  5  to ALU
- alu_control_signal  out  3  to ALU
- ex_rd  out  RW  destination register
- ex_reg_write  out  1  registered, gated by ex_valid
- ex_mem_read  out  1  registered, gated by ex_valid
- ex_mem_write  out  1  registered, gated by ex_valid
- store_data  out  DW  forwarded rt value

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline register clears to 0, so ex_valid=0 and all control=0. With registered rs=rt=0, no forwarding matches, so opA=opB=store_data=0 and stall=0.
- Load-use hazard, combinational: hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs==ex_rd | (id_uses_rt & id_rt==ex_rd)).
- stall = hazard & ~flush.
- Register update on each rising clk, in priority order:
  - flush, or hazard, or ~id_valid: load a bubble. ex_valid, reg_write, mem_read and mem_write become 0, and alu_control_signal becomes 000 (ADD).
  - Otherwise: capture all id_* fields.
- Capture-time WB bypass: if mwb_reg_write & mwb_rd!=0 & mwb_rd==id_rs, the rs data register takes mwb_result instead of id_rs_data. The same rule applies to rt.
- Latency: an instruction reaches the ALU inputs exactly 1 cycle after capture. A stall adds exactly 1 bubble cycle; the next cycle re-evaluates.
- Operand forwarding is combinational from the registered fields, for rs and for rt independently:
  - First, if exm_reg_write & exm_rd!=0 & exm_rd==reg_rs, use exm_result.
  - Else, if mwb_reg_write & mwb_rd!=0 & mwb_rd==reg_rs, use mwb_result.
  - Else, use the registered data.
  - EX/MEM has priority over MEM/WB for the same address. Register $0 is never forwarded.
- opA = forwarded rs.
- opB = reg_alu_src_imm ? reg_imm : forwarded rt.
- store_data = forwarded rt, regardless of alu_src_imm.
- The ALU opcodes are exactly ADD=000, SUB=001, SLL=010, NOR=011, AND=100, SLT=101. Any other code passes through unchanged.
- Reset asserted mid-operation: the in-flight instruction is dropped and stall deasserts immediately.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants (ADD, SUB, SLL, NOR, AND, SLT);
  - the REG_ZERO constant;
  - the DW/RW defaults.
- One natural sub-module, fwd_mux: the per-operand priority forwarding select, instantiated twice (rs and rt).

Test Plan:
- Reset: assert rst_n=0 mid-stream -> opA=opB=0, ex_valid=0, stall=0 immediately, with no clock edge needed.
- EX/MEM forwarding: add $3=$1+$2 followed by sub $4=$3-$5, with exm_rd=3, exm_result=0x0000_0010 and registered rt data 0x5 -> opA=0x10, opB=0x5, alu_control_signal=001.
- Double-hazard priority: exm_rd=mwb_rd=7, exm_result=0xAAAA, mwb_result=0xBBBB, instruction reads $7 -> opA=0xAAAA. With exm_rd=0 and mwb_rd=0 (both reg_write=1) -> opA=registered value, no forwarding.
- Load-use: lw $8 in EX (ex_mem_read=1, ex_rd=8), decode add using rs=8 -> stall=1 for exactly 1 cycle and a bubble enters EX (ex_valid=0, ex_reg_write=0). On the next cycle the add is captured, and with mwb_rd=8 it forwards mwb_result.
- Flush overrides hazard: the load-use condition plus flush=1 -> stall=0, and a bubble is loaded.
- Immediate/shift: addi with id_alu_src_imm=1 and id_imm=0xFFFF_FFFC, rt forwarded to 0x99 -> opB=0xFFFF_FFFC and store_data=0x99. sll with shamt=4 -> shamt=4, alu_control_signal=010.
